// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Holds the RV32 load/store funct3 encodings, the arbiter FSM state encoding and
// the alignment/legality helpers used when a latched command is checked.
package dmem_arbiter_pkg;

  // Load encodings
  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  // Store encodings
  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  // Half accesses (x01) need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    if (funct3[1:0] == Funct3Lh[1:0] && addr_lo[0]) mis = 1'b1;
    if (funct3 == Funct3Lw && addr_lo != 2'b00)     mis = 1'b1;
    return mis;
  endfunction

  // Unknown funct3, or a store using an unsigned-load encoding.
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    logic legal;
    case (funct3)
      Funct3Lb, Funct3Lh, Funct3Lw, Funct3Lbu, Funct3Lhu: legal = 1'b1;
      default:                                            legal = 1'b0;
    endcase
    return !legal || (we && funct3[2]);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker.
// Ports:
//   req_i  per-port request
//   ptr_i  preferred port when both request
//   id_o   winning port
//   any_o  at least one request present
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       id_o,
  output logic       any_o
);

  assign any_o = |req_i;
  // A lone request always wins; the pointer only breaks ties.
  assign id_o  = (req_i == 2'b11) ? ptr_i : req_i[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port data memory between the core LSU (port 0) and
// a debug/DMA loader (port 1). Each access runs IDLE -> GRANT -> ACCESS -> RESP.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_i/we_i/funct3_i   per-port command (request held until gnt_o)
//   addr_i/wdata_i        per-port byte address and LSB-aligned store data
//   gnt_o                 pulse: command latched
//   rvalid_o              pulse: response valid; rdata_o/err_o qualify it
//   busy_o                high outside IDLE
//   mem_*                 single-port memory interface (combinational read)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 we_i,
  input  logic [1:0][2:0]            funct3_i,
  input  logic [1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 rvalid_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic                       mem_wr_en_o,
  output logic [2:0]                 mem_funct3_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0]      mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]      mem_rdata_i
);

  state_e                  state_q;
  logic                    rr_ptr_q;
  logic                    id_q;
  logic                    cmd_we_q;
  logic [2:0]              cmd_funct3_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [DATA_WIDTH-1:0]   cmd_wdata_q;
  logic                    cmd_err_q;
  logic [1:0]              gnt_q;
  logic [1:0]              rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    busy_q;
  logic                    mem_wr_en_q;
  logic [2:0]              mem_funct3_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;

  logic win_id;
  logic win_any;
  logic cmd_err_d;

  rr_arb2 u_rr_arb2 (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .id_o  (win_id),
    .any_o (win_any)
  );

  assign cmd_err_d = is_illegal(cmd_we_q, cmd_funct3_q) |
                     is_misaligned(cmd_funct3_q, cmd_addr_q[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= 1'b0;
      id_q         <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_funct3_q <= 3'b000;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_err_q    <= 1'b0;
      gnt_q        <= 2'b00;
      rvalid_q     <= 2'b00;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_funct3_q <= 3'b000;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      // Pulse outputs default low; each is raised for the one state that owns it.
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      mem_wr_en_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (win_any) begin
            id_q          <= win_id;
            cmd_we_q      <= we_i[win_id];
            cmd_funct3_q  <= funct3_i[win_id];
            cmd_addr_q    <= addr_i[win_id];
            cmd_wdata_q   <= wdata_i[win_id];
            gnt_q[win_id] <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= StGrant;
          end
        end
        StGrant: begin
          cmd_err_q    <= cmd_err_d;
          rr_ptr_q     <= ~id_q;
          mem_funct3_q <= cmd_funct3_q;
          mem_addr_q   <= cmd_addr_q;
          mem_wdata_q  <= cmd_wdata_q;
          mem_wr_en_q  <= cmd_we_q & ~cmd_err_d;
          state_q      <= StAccess;
        end
        StAccess: begin
          rvalid_q[id_q] <= 1'b1;
          err_q          <= cmd_err_q;
          if (!cmd_we_q && !cmd_err_q) rdata_q <= mem_rdata_i;
          state_q        <= StResp;
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Reset takes effect within the same cycle for the strobes, so a write that
  // is in flight when reset rises never reaches memory.
  assign gnt_o        = gnt_q & {2{~reset}};
  assign rvalid_o     = rvalid_q & {2{~reset}};
  assign mem_wr_en_o  = mem_wr_en_q & ~reset;
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;
  assign busy_o       = busy_q;
  assign mem_funct3_o = mem_funct3_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
